// File: rtl/sensor_scan_scheduler.sv
// Round-robin scan sequencer that shares one ADC between the soil (ch0),
// DHT11 temperature (ch1) and rain (ch2) sensors. Each scan converts the
// three channels in order, latches the results and pulses sample_valid.
// Successive scans start on a fixed period.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | scanning disabled; leaves when enable=1 and hold=0
// START    | one-cycle adc_start for the current channel
// CONVERT  | waiting for adc_done, bounded by the conversion timeout
// NEXT     | one-cycle channel advance or end-of-scan bookkeeping
// WAIT     | scan complete; waiting out the rest of the sample period
module sensor_scan_scheduler #(
   parameter int SAMPLE_PERIOD = 100,
   parameter int CONV_TIMEOUT  = 16,
   parameter int DATA_W        = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              hold,
   output logic              adc_start,
   output logic [1:0]        adc_ch,
   input  logic              adc_done,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] soil_digital,
   output logic [DATA_W-1:0] dht11_digital,
   output logic [DATA_W-1:0] rain_digital,
   output logic              sample_valid,
   output logic [7:0]        scan_count,
   output logic              busy,
   output logic              timeout_err,
   output logic [1:0]        err_ch
);

   localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int TO_W  = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;

   localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CONV_TIMEOUT - 1);
   localparam logic [1:0]       CH_LAST  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_CONVERT,
      S_NEXT,
      S_WAIT
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       ch;
   logic [1:0]       ch_nxt;
   logic [PER_W-1:0] per_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             conv_ok;
   logic             conv_to;
   logic             scan_end;
   logic             period_restart;

   // State and channel registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         ch    <= 2'd0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
      end
   end

   // Next-state logic and per-cycle strobes.
   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      conv_ok   = 1'b0;
      conv_to   = 1'b0;
      scan_end  = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable && !hold) begin
               state_nxt = S_START;
               ch_nxt    = 2'd0;
            end
         end
         S_START: begin
            state_nxt = S_CONVERT;
         end
         S_CONVERT: begin
            // A done arriving on the last allowed cycle still counts as good data.
            if (adc_done) begin
               conv_ok   = 1'b1;
               state_nxt = S_NEXT;
            end else if (to_cnt == TO_LAST) begin
               conv_to   = 1'b1;
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            if (!enable) begin
               // Abandon the partial scan; a later enable restarts from ch0.
               state_nxt = S_IDLE;
               ch_nxt    = 2'd0;
            end else if (ch == CH_LAST) begin
               scan_end  = 1'b1;
               state_nxt = S_WAIT;
               ch_nxt    = 2'd0;
            end else begin
               state_nxt = S_START;
               ch_nxt    = ch + 2'd1;
            end
         end
         S_WAIT: begin
            if (!enable) begin
               state_nxt = S_IDLE;
            end else if ((per_cnt == PER_LAST) && !hold) begin
               state_nxt = S_START;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            ch_nxt    = 2'd0;
         end
      endcase
   end

   // Only entries into a ch0 START begin a new period.
   assign period_restart = ((state == S_IDLE) || (state == S_WAIT)) &&
                           (state_nxt == S_START);

   // Period counter: reads 0 during the ch0 START and saturates at the last count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         per_cnt <= '0;
      end else if (period_restart) begin
         per_cnt <= '0;
      end else if (per_cnt != PER_LAST) begin
         per_cnt <= per_cnt + PER_W'(1);
      end
   end

   // Conversion timeout counter: zeroed in START, counts CONVERT cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (state == S_START) begin
         to_cnt <= '0;
      end else if (state == S_CONVERT) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Result capture into the per-sensor registers; timeouts leave them untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         soil_digital  <= '0;
         dht11_digital <= '0;
         rain_digital  <= '0;
      end else if (conv_ok) begin
         case (ch)
            2'd0:    soil_digital  <= adc_data;
            2'd1:    dht11_digital <= adc_data;
            default: rain_digital  <= adc_data;
         endcase
      end
   end

   // Sticky timeout flag with the channel of the most recent timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_err <= 1'b0;
         err_ch      <= 2'd0;
      end else if (conv_to) begin
         timeout_err <= 1'b1;
         err_ch      <= ch;
      end
   end

   // Completed-scan counter, wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_count <= 8'd0;
      end else if (scan_end) begin
         scan_count <= scan_count + 8'd1;
      end
   end

   assign adc_start    = (state == S_START);
   assign adc_ch       = ch;
   assign sample_valid = scan_end;
   assign busy         = (state == S_START) || (state == S_CONVERT) || (state == S_NEXT);

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Bench for sensor_scan_scheduler: directed scenarios plus a randomized run,
// all checked cycle by cycle against a timestamp-based model of the scan rules.
module tb_sensor_scan_scheduler;

   localparam int SAMPLE_PERIOD = 100;
   localparam int CONV_TIMEOUT  = 16;
   localparam int DATA_W        = 10;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic              hold = 1'b0;
   logic              adc_done = 1'b0;
   logic [DATA_W-1:0] adc_data = '0;
   logic              adc_start;
   logic [1:0]        adc_ch;
   logic [DATA_W-1:0] soil_digital;
   logic [DATA_W-1:0] dht11_digital;
   logic [DATA_W-1:0] rain_digital;
   logic              sample_valid;
   logic [7:0]        scan_count;
   logic              busy;
   logic              timeout_err;
   logic [1:0]        err_ch;

   sensor_scan_scheduler #(
      .SAMPLE_PERIOD (SAMPLE_PERIOD),
      .CONV_TIMEOUT  (CONV_TIMEOUT),
      .DATA_W        (DATA_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .hold          (hold),
      .adc_start     (adc_start),
      .adc_ch        (adc_ch),
      .adc_done      (adc_done),
      .adc_data      (adc_data),
      .soil_digital  (soil_digital),
      .dht11_digital (dht11_digital),
      .rain_digital  (rain_digital),
      .sample_valid  (sample_valid),
      .scan_count    (scan_count),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .err_ch        (err_ch)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: expectations expressed as cycle timestamps.
   logic [DATA_W-1:0] m_reg [4];
   bit                m_to_err;
   int                m_err_ch;
   int                m_scan_cnt;
   int                m_scans_total;
   bit                m_idle;
   bit                m_scanning;
   bit                m_waiting;
   int                m_conv_start;
   int                m_conv_end;
   int                m_conv_ch;
   int                m_last_ch0;
   bit                m_start_due;
   int                m_start_ch;

   // Stimulus knobs and responder state.
   bit                en_drv = 1'b0;
   bit                hold_drv = 1'b0;
   int                lat_fixed = 0;
   bit                data_table = 1'b0;
   int                drop_ch = -1;
   bit                spurious_en = 1'b0;
   int                resp_cyc = -1;
   logic [DATA_W-1:0] resp_data = '0;
   logic [DATA_W-1:0] tbl [4];
   logic [DATA_W-1:0] sent_data [4];

   // Observation bookkeeping.
   bit sv_seen;
   bit start_seen;
   int start_seen_ch;
   int start_cnt = 0;
   int sv_total = 0;
   int last_obs_ch0 = -1;
   int prev_obs_ch0 = -1;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_to_err      = 1'b0;
      m_err_ch      = 0;
      m_scan_cnt    = 0;
      m_scans_total = 0;
      m_idle        = 1'b1;
      m_scanning    = 1'b0;
      m_waiting     = 1'b0;
      m_conv_start  = -1;
      m_conv_end    = -1;
      m_conv_ch     = 0;
      m_last_ch0    = -1000;
      m_start_due   = 1'b0;
      m_start_ch    = 0;
      resp_cyc      = -1;
   endtask

   // Advance the model across the clock edge that ends the current cycle.
   task automatic model_step();
      bit due;
      int dch;
      due = 1'b0;
      dch = 0;
      if (m_scanning && (m_conv_end < 0) && (cyc > m_conv_start)) begin
         if (adc_done) begin
            m_reg[m_conv_ch] = adc_data;
            m_conv_end = cyc;
         end else if (cyc == m_conv_start + CONV_TIMEOUT) begin
            m_to_err   = 1'b1;
            m_err_ch   = m_conv_ch;
            m_conv_end = cyc;
         end
      end else if (m_scanning && (m_conv_end >= 0)) begin
         m_scanning = 1'b0;
         if (!enable) begin
            m_idle = 1'b1;
         end else if (m_conv_ch < 2) begin
            due = 1'b1;
            dch = m_conv_ch + 1;
         end else begin
            m_scan_cnt = (m_scan_cnt + 1) % 256;
            m_scans_total++;
            m_waiting = 1'b1;
         end
      end else if (m_waiting) begin
         if (!enable) begin
            m_waiting = 1'b0;
            m_idle    = 1'b1;
         end else if ((cyc >= m_last_ch0 + SAMPLE_PERIOD - 1) && !hold) begin
            m_waiting = 1'b0;
            due = 1'b1;
            dch = 0;
         end
      end else if (m_idle) begin
         if (enable && !hold) begin
            m_idle = 1'b0;
            due = 1'b1;
            dch = 0;
         end
      end
      m_start_due = due;
      m_start_ch  = dch;
      if (due) begin
         m_scanning   = 1'b1;
         m_conv_start = cyc + 1;
         m_conv_end   = -1;
         m_conv_ch    = dch;
         if (dch == 0) m_last_ch0 = cyc + 1;
      end
   endtask

   // One clock cycle: check state-driven outputs, drive inputs, check the rest, step the model.
   task automatic cycle();
      int  lat;
      int  r;
      bit  exp_sv;
      @(posedge clk);
      #1;
      cyc++;
      check_val("adc_start", 32'(adc_start), 32'(m_start_due));
      if (m_start_due) check_val("adc_ch", 32'(adc_ch), 32'(m_start_ch));
      check_val("busy", 32'(busy), 32'(m_scanning));
      start_seen    = adc_start;
      start_seen_ch = int'(adc_ch);

      if (adc_start) begin
         start_cnt++;
         if (adc_ch == 2'd0) begin
            prev_obs_ch0 = last_obs_ch0;
            last_obs_ch0 = cyc;
         end
         resp_data = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         if (data_table) resp_data = tbl[adc_ch];
         sent_data[adc_ch] = resp_data;
         if (drop_ch == int'(adc_ch)) begin
            lat = 0;
         end else if (lat_fixed != 0) begin
            lat = lat_fixed;
         end else begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      lat = 0;
            else if (r == 1) lat = CONV_TIMEOUT;
            else if (r == 2) lat = CONV_TIMEOUT + 1;
            else             lat = int'($urandom_range(1, CONV_TIMEOUT - 1));
         end
         resp_cyc = (lat == 0) ? -1 : cyc + lat;
      end

      enable   = en_drv;
      hold     = hold_drv;
      adc_data = DATA_W'($urandom);
      adc_done = 1'b0;
      if (cyc == resp_cyc) begin
         adc_done = 1'b1;
         adc_data = resp_data;
      end else if (spurious_en && !(m_scanning && (m_conv_end < 0)) &&
                   ($urandom_range(0, 19) == 0)) begin
         adc_done = 1'b1;
      end

      #1;
      exp_sv = m_scanning && (m_conv_end >= 0) && (m_conv_ch == 2) && enable;
      check_val("sample_valid", 32'(sample_valid), 32'(exp_sv));
      sv_seen = sample_valid;
      if (sample_valid) sv_total++;
      check_val("soil_digital", 32'(soil_digital), 32'(m_reg[0]));
      check_val("dht11_digital", 32'(dht11_digital), 32'(m_reg[1]));
      check_val("rain_digital", 32'(rain_digital), 32'(m_reg[2]));
      check_val("timeout_err", 32'(timeout_err), 32'(m_to_err));
      check_val("err_ch", 32'(err_ch), 32'(m_err_ch));
      check_val("scan_count", 32'(scan_count), 32'(m_scan_cnt));
      model_step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_sv(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!sv_seen && (n < budget));
      check_val({tag, "_sv_seen"}, 32'(sv_seen), 32'd1);
   endtask

   task automatic wait_start(input string tag, input int want_ch, input int budget);
      int n;
      bit hit;
      n = 0;
      hit = 1'b0;
      do begin
         cycle();
         n++;
         hit = start_seen && ((want_ch < 0) || (start_seen_ch == want_ch));
      end while (!hit && (n < budget));
      check_val({tag, "_start_seen"}, 32'(hit), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_adc_start"}, 32'(adc_start), 32'd0);
      check_val({tag, "_adc_ch"}, 32'(adc_ch), 32'd0);
      check_val({tag, "_soil"}, 32'(soil_digital), 32'd0);
      check_val({tag, "_dht11"}, 32'(dht11_digital), 32'd0);
      check_val({tag, "_rain"}, 32'(rain_digital), 32'd0);
      check_val({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
      check_val({tag, "_scan_count"}, 32'(scan_count), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
      check_val({tag, "_err_ch"}, 32'(err_ch), 32'd0);
   endtask

   // Asynchronous reset asserted mid-cycle, outputs checked before any clock edge.
   task automatic do_reset(input string tag);
      reset    = 1'b0;
      en_drv   = 1'b0;
      hold_drv = 1'b0;
      enable   = 1'b0;
      hold     = 1'b0;
      adc_done = 1'b0;
      #1;
      check_zero(tag);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int s0;
      int v0;
      int n;
      tbl[0] = 10'h12A;
      tbl[1] = 10'h0C8;
      tbl[2] = 10'h3FF;
      tbl[3] = 10'h000;
      for (int i = 0; i < 4; i++) sent_data[i] = '0;
      model_reset();

      #2;
      check_zero("por");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Nominal scan with a 3-cycle ADC and fixed results, then period spacing.
      en_drv     = 1'b1;
      lat_fixed  = 3;
      data_table = 1'b1;
      wait_sv("t1", 300);
      check_val("t1_soil", 32'(soil_digital), 32'd298);
      check_val("t1_dht11", 32'(dht11_digital), 32'd200);
      check_val("t1_rain", 32'(rain_digital), 32'd1023);
      cycle();
      check_val("t1_scan_count", 32'(scan_count), 32'd1);
      wait_start("t1_ch0", 0, 300);
      check_val("t1_period", 32'(last_obs_ch0 - prev_obs_ch0), 32'd100);

      // ch1 never answers: timeout recorded, old value kept, scan still completes.
      drop_ch = 1;
      wait_sv("t2", 300);
      check_val("t2_timeout_err", 32'(timeout_err), 32'd1);
      check_val("t2_err_ch", 32'(err_ch), 32'd1);
      check_val("t2_dht11_kept", 32'(dht11_digital), 32'd200);
      check_val("t2_rain", 32'(rain_digital), 32'd1023);
      drop_ch = -1;
      cycle();

      // Done on the exact timeout cycle is good data.
      do_reset("t3_rst");
      en_drv     = 1'b1;
      lat_fixed  = CONV_TIMEOUT;
      data_table = 1'b1;
      wait_sv("t3", 300);
      check_val("t3_timeout_err", 32'(timeout_err), 32'd0);
      check_val("t3_soil", 32'(soil_digital), 32'd298);
      check_val("t3_dht11", 32'(dht11_digital), 32'd200);
      check_val("t3_rain", 32'(rain_digital), 32'd1023);

      // hold high for period cycles 90..130 delays the next ch0 start.
      lat_fixed = 3;
      wait_start("t4_ch0", 0, 300);
      t0 = cyc;
      while (cyc < t0 + 89) cycle();
      hold_drv = 1'b1;
      while (cyc < t0 + 130) cycle();
      hold_drv = 1'b0;
      wait_start("t4_next_ch0", 0, 300);
      check_val("t4_delayed_start", 32'(cyc - t0), 32'd132);

      // enable drops during ch1 CONVERT: result kept, scan abandoned, restart at ch0.
      data_table = 1'b0;
      wait_start("t5_ch1", 1, 300);
      en_drv = 1'b0;
      s0 = start_cnt;
      v0 = sv_total;
      run(30);
      check_val("t5_no_more_starts", 32'(start_cnt - s0), 32'd0);
      check_val("t5_no_sample_valid", 32'(sv_total - v0), 32'd0);
      check_val("t5_idle_busy", 32'(busy), 32'd0);
      check_val("t5_dht11_stored", 32'(dht11_digital), 32'(sent_data[1]));
      en_drv = 1'b1;
      wait_start("t5_restart", -1, 50);
      check_val("t5_restart_ch", 32'(start_seen_ch), 32'd0);

      // Reset in CONVERT, then a late adc_done that must be ignored.
      cycle();
      do_reset("t6_rst");
      adc_done = 1'b1;
      adc_data = 10'h155;
      @(posedge clk);
      #1;
      adc_done = 1'b0;
      check_val("t6_late_soil", 32'(soil_digital), 32'd0);
      check_val("t6_late_busy", 32'(busy), 32'd0);
      model_reset();

      // Randomized run until 256 complete scans; scan_count must wrap to 0.
      lat_fixed   = 0;
      spurious_en = 1'b1;
      en_drv      = 1'b1;
      n = 0;
      while ((m_scans_total < 256) && (n < 60000)) begin
         if (!hold_drv && ($urandom_range(0, 149) == 0)) hold_drv = 1'b1;
         else if (hold_drv && ($urandom_range(0, 19) == 0)) hold_drv = 1'b0;
         if (en_drv && ($urandom_range(0, 499) == 0)) en_drv = 1'b0;
         else if (!en_drv && ($urandom_range(0, 7) == 0)) en_drv = 1'b1;
         cycle();
         n++;
      end
      check_val("rand_scans_done", 32'(m_scans_total), 32'd256);
      cycle();
      check_val("wrap_scan_count", 32'(scan_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
